// File: rtl/cpu_pkg.sv
// Shared datapath width defaults for the CPU pipeline registers.
package cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_REG_AW = 4;
endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop: async active-low reset to 0, synchronous clear, hold enable.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear dominates hold so a bubble can be inserted into a stalled stage.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (!hold) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/ex_wb_register.sv
// EX->WB pipeline register with stall/flush and forwarding address-match flags.
module ex_wb_register
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] regs_bank_in,
  input  logic [DATA_W-1:0] mux2_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [REG_AW-1:0] regC_adress_in,
  input  logic              write_inst_in,
  input  logic [REG_AW-1:0] src_a_addr,
  input  logic [REG_AW-1:0] src_b_addr,
  output logic [DATA_W-1:0] regs_bank_out,
  output logic [DATA_W-1:0] mux2_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [REG_AW-1:0] regC_adress_out,
  output logic              write_inst_out,
  output logic              valid_out,
  output logic              fwd_a_match,
  output logic              fwd_b_match
);
  pipe_reg #(.WIDTH(DATA_W)) u_regs_bank (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(regs_bank_in), .q(regs_bank_out)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_mux2 (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(mux2_in), .q(mux2_out)
  );

  pipe_reg #(.WIDTH(PC_W)) u_pc (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(pc_in), .q(pc_out)
  );

  pipe_reg #(.WIDTH(REG_AW)) u_regc (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(regC_adress_in), .q(regC_adress_out)
  );

  pipe_reg #(.WIDTH(1)) u_write (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(write_inst_in), .q(write_inst_out)
  );

  // Any load brings in a real instruction; only flush or reset creates a bubble.
  pipe_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .hold(stall), .clr(flush),
    .d(1'b1), .q(valid_out)
  );

  // Register 0 is deliberately not excluded from matching.
  assign fwd_a_match = write_inst_out & valid_out & (regC_adress_out == src_a_addr);
  assign fwd_b_match = write_inst_out & valid_out & (regC_adress_out == src_b_addr);
endmodule

// File: tb/tb_ex_wb_register.sv
// Directed bench for ex_wb_register: reset, load, stall, flush, forwarding and async reset.
module tb_ex_wb_register;
  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] regs_bank_in;
  logic [31:0] mux2_in;
  logic [31:0] pc_in;
  logic [3:0]  regC_adress_in;
  logic        write_inst_in;
  logic [3:0]  src_a_addr;
  logic [3:0]  src_b_addr;
  logic [31:0] regs_bank_out;
  logic [31:0] mux2_out;
  logic [31:0] pc_out;
  logic [3:0]  regC_adress_out;
  logic        write_inst_out;
  logic        valid_out;
  logic        fwd_a_match;
  logic        fwd_b_match;

  int vectors;
  int miscompares;

  ex_wb_register dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .regs_bank_in(regs_bank_in), .mux2_in(mux2_in), .pc_in(pc_in),
    .regC_adress_in(regC_adress_in), .write_inst_in(write_inst_in),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .regs_bank_out(regs_bank_out), .mux2_out(mux2_out), .pc_out(pc_out),
    .regC_adress_out(regC_adress_out), .write_inst_out(write_inst_out),
    .valid_out(valid_out), .fwd_a_match(fwd_a_match), .fwd_b_match(fwd_b_match)
  );

  // Clock/reset block: clock can be parked low to observe reset without edges.
  initial clk = 1'b0;
  always begin
    #5;
    clk = clk_en ? ~clk : clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] rb, input logic [31:0] m2,
                           input logic [31:0] pc, input logic [3:0] rc, input logic wr,
                           input logic vl);
    check({tag, "_regs_bank"}, 64'(regs_bank_out), 64'(rb));
    check({tag, "_mux2"}, 64'(mux2_out), 64'(m2));
    check({tag, "_pc"}, 64'(pc_out), 64'(pc));
    check({tag, "_regc"}, 64'(regC_adress_out), 64'(rc));
    check({tag, "_write"}, 64'(write_inst_out), 64'(wr));
    check({tag, "_valid"}, 64'(valid_out), 64'(vl));
  endtask

  task automatic drive_load(input logic [31:0] rb, input logic [31:0] m2, input logic [31:0] pc,
                            input logic [3:0] rc, input logic wr);
    regs_bank_in   = rb;
    mux2_in        = m2;
    pc_in          = pc;
    regC_adress_in = rc;
    write_inst_in  = wr;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    rst_n       = 1'b0;
    stall       = 1'b1;
    flush       = 1'b1;
    src_a_addr  = 4'd3;
    src_b_addr  = 4'd3;
    drive_load(32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 4'd3, 1'b1);

    // Reset with no clock running.
    #10;
    check_all("reset", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    check("reset_fwd_a", 64'(fwd_a_match), 64'd0);
    check("reset_fwd_b", 64'(fwd_b_match), 64'd0);

    #2 rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive_load(32'd620, 32'd470, 32'h10, 4'd5, 1'b1);
    src_a_addr = 4'd0;
    src_b_addr = 4'd0;
    #3 clk_en = 1'b1;

    // Load.
    edge_sample();
    check_all("load", 32'd620, 32'd470, 32'h10, 4'd5, 1'b1, 1'b1);
    src_a_addr = 4'd5;
    src_b_addr = 4'd8;
    #1;
    check("load_fwd_a", 64'(fwd_a_match), 64'd1);
    check("load_fwd_b", 64'(fwd_b_match), 64'd0);

    // Stall for three edges with changed inputs.
    @(negedge clk);
    stall = 1'b1;
    drive_load(32'd999, 32'd111, 32'h20, 4'd13, 1'b0);
    repeat (3) edge_sample();
    check_all("stall", 32'd620, 32'd470, 32'h10, 4'd5, 1'b1, 1'b1);
    check("stall_fwd_a", 64'(fwd_a_match), 64'd1);

    // Flush wins over stall; address 0 must not match a bubble.
    @(negedge clk);
    flush = 1'b1;
    src_a_addr = 4'd0;
    src_b_addr = 4'd0;
    edge_sample();
    check_all("flush", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    check("flush_fwd_a", 64'(fwd_a_match), 64'd0);
    check("flush_fwd_b", 64'(fwd_b_match), 64'd0);

    // Non-writing instruction never forwards.
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    drive_load(32'd7, 32'd8, 32'h24, 4'd10, 1'b0);
    src_a_addr = 4'd10;
    src_b_addr = 4'd10;
    edge_sample();
    check_all("nowrite", 32'd7, 32'd8, 32'h24, 4'd10, 1'b0, 1'b1);
    check("nowrite_fwd_a", 64'(fwd_a_match), 64'd0);
    check("nowrite_fwd_b", 64'(fwd_b_match), 64'd0);

    // Register 0 matches like any other register.
    @(negedge clk);
    drive_load(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h28, 4'd0, 1'b1);
    src_a_addr = 4'd1;
    src_b_addr = 4'd0;
    edge_sample();
    check_all("reg0", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h28, 4'd0, 1'b1, 1'b1);
    check("reg0_fwd_a", 64'(fwd_a_match), 64'd0);
    check("reg0_fwd_b", 64'(fwd_b_match), 64'd1);

    // Async reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    check("async_rst_fwd_b", 64'(fwd_b_match), 64'd0);

    // First edge after release performs a normal load.
    @(negedge clk);
    rst_n = 1'b1;
    drive_load(32'h0BAD_F00D, 32'hCAFE_0001, 32'h2C, 4'd15, 1'b1);
    src_a_addr = 4'd15;
    src_b_addr = 4'd14;
    edge_sample();
    check_all("post_rst", 32'h0BAD_F00D, 32'hCAFE_0001, 32'h2C, 4'd15, 1'b1, 1'b1);
    check("post_rst_fwd_a", 64'(fwd_a_match), 64'd1);
    check("post_rst_fwd_b", 64'(fwd_b_match), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
